seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 108 ++++++++++
 tb/tb_seq_multiplier.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add sequential multiplier with an IDLE/CALC/DONE FSM.
// Define SEQ_MULT_SIGNED_EN to add the signed_mode port (two's complement).
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mc;
  logic [WIDTH-1:0]   mp;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               sgn;
  logic               sgn_in;
  logic [2*WIDTH-1:0] mc_init;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               last;

`ifdef SEQ_MULT_SIGNED_EN
  assign sgn_in = signed_mode;
`else
  assign sgn_in = 1'b0;
`endif

  assign mc_init = {{WIDTH{sgn_in & A[WIDTH-1]}}, A};
  assign last    = (cnt == LAST);

  // Signed mode: the multiplier MSB carries negative weight.
  always_comb begin
    addend = mp[0] ? mc : '0;
    if (sgn && last)
      acc_nxt = acc - addend;
    else
      acc_nxt = acc + addend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mc    <= '0;
      mp    <= '0;
      acc   <= '0;
      cnt   <= '0;
      sgn   <= 1'b0;
      out   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (enable && start) begin
            mc    <= mc_init;
            mp    <= B;
            sgn   <= sgn_in;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (enable) begin
            acc <= acc_nxt;
            mc  <= mc << 1;
            mp  <= mp >> 1;
            cnt <= cnt + CW'(1);
            if (last) begin
              out   <= acc_nxt;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (WIDTH=4) with expected-product queue.
// Signed cases run when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_multiplier;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
`ifdef SEQ_MULT_SIGNED_EN
  logic       signed_mode;
`endif
  logic       busy;
  logic       done;
  logic [7:0] out;

  int total;
  int passed;
  logic [7:0] sb[$];

  seq_multiplier #(.WIDTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .start(start),
    .A(A),
    .B(B),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .busy(busy),
    .done(done),
    .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model(input logic [3:0] a,
                                       input logic [3:0] b,
                                       input logic sm);
    int sa;
    int sb_;
    int p;
    if (sm) begin
      sa = $signed(a);
      sb_ = $signed(b);
    end else begin
      sa = int'(a);
      sb_ = int'(b);
    end
    p = sa * sb_;
    return p[7:0];
  endfunction

  // Start an op now, wait for done; returns in the DONE cycle.
  task automatic op(input string tag, input logic [3:0] a,
                    input logic [3:0] b, input logic sm,
                    input int lat);
    int n;
    logic [7:0] e;
    A = a;
    B = b;
`ifdef SEQ_MULT_SIGNED_EN
    signed_mode = sm;
`endif
    start = 1'b1;
    sb.push_back(model(a, b, sm));
    tick();
    start = 1'b0;
    A = ~a;
    B = ~b;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    chk({tag, "_out"}, 32'(out), 32'(e));
    chk({tag, "_nbusy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    total = 0;
    passed = 0;
    enable = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
`ifdef SEQ_MULT_SIGNED_EN
    signed_mode = 1'b0;
`endif
    rst_n = 1'b0;
    #12;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // 15*15 with explicit edge timing
    A = 4'd15;
    B = 4'd15;
    start = 1'b1;
    sb.push_back(model(4'd15, 4'd15, 1'b0));
    tick();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("ff_busy_e%0d", i), 32'(busy), 32'd1);
      chk($sformatf("ff_done_e%0d", i), 32'(done), 32'd0);
      chk($sformatf("ff_out_e%0d", i), 32'(out), 32'd0);
    end
    tick();
    chk("ff_done", 32'(done), 32'd1);
    chk("ff_out", 32'(out), 32'(sb.pop_front()));
    chk("ff_out_const", 32'(out), 32'h00E1);
    tick();
    chk("ff_done_pulse", 32'(done), 32'd0);
    chk("ff_hold", 32'(out), 32'h00E1);
    chk("ff_idle", 32'(busy), 32'd0);

    // zero operand, then back-to-back from DONE
    op("zero", 4'd0, 4'd9, 1'b0, 4);
    op("b2b", 4'd3, 4'd5, 1'b0, 4);
    chk("b2b_const", 32'(out), 32'h0F);

    tick();
    tick();
    // 6*7 with a stall and an ignored start while busy
    A = 4'd6;
    B = 4'd7;
    start = 1'b1;
    sb.push_back(model(4'd6, 4'd7, 1'b0));
    tick();
    A = 4'd1;
    B = 4'd1;
    tick();
    start = 1'b0;
    tick();
    enable = 1'b0;
    tick();
    tick();
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_done", 32'(done), 32'd0);
    enable = 1'b1;
    tick();
    chk("stall_e5_done", 32'(done), 32'd0);
    tick();
    chk("stall_e6_done", 32'(done), 32'd1);
    chk("stall_out", 32'(out), 32'(sb.pop_front()));
    chk("stall_out_const", 32'(out), 32'h2A);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("stall_nodone%0d", i), 32'(done), 32'd0);
    end
    chk("stall_hold", 32'(out), 32'h2A);

    // reset mid-operation
    A = 4'd9;
    B = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_out", 32'(out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("arst_nodone%0d", i), 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);
    op("post_rst", 4'd2, 4'd3, 1'b0, 4);
    chk("post_rst_const", 32'(out), 32'h06);

    // random unsigned back-to-back
    for (int i = 0; i < 8; i++)
      op($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)),
         4'($urandom_range(0, 15)), 1'b0, 4);

`ifdef SEQ_MULT_SIGNED_EN
    op("s_m8m8", 4'h8, 4'h8, 1'b1, 4);
    chk("s_m8m8_c", 32'(out), 32'h40);
    op("s_m8p7", 4'h8, 4'h7, 1'b1, 4);
    chk("s_m8p7_c", 32'(out), 32'hC8);
    op("s_p7m1", 4'h7, 4'hF, 1'b1, 4);
    chk("s_p7m1_c", 32'(out), 32'hF9);
    op("s_uns", 4'hF, 4'hF, 1'b0, 4);
    chk("s_uns_c", 32'(out), 32'hE1);
    for (int i = 0; i < 6; i++)
      op($sformatf("srnd%0d", i), 4'($urandom_range(0, 15)),
         4'($urandom_range(0, 15)), 1'b1, 4);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
